// File: rtl/adder_pkg.sv
// Shared types and elaboration-time helpers for the chunked serial adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Index counter is at least one bit wide so NCHUNK == 1 still has a register.
  function automatic int calc_idx_width(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/ripple_chunk.sv
// Purely combinational ripple of CHUNK full-adder cells; also reports the
// carry into the top bit so the caller can derive signed overflow.
module ripple_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: a + b + ci computed CHUNK bits per clock with a carry
// register between chunks, wrapped in valid/ready handshakes.
module chunked_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready depends only on state and rst; out_valid only on state, and the
  // result fields stay frozen while out_valid is high and out_ready is low.

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDXW   = calc_idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  logic             accept;
  logic             drain;
  logic             last_chunk;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_cout;
  logic             chunk_cmsb;
  logic [WIDTH-1:0] sum_shifted;

  ripple_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_q[CHUNK-1:0]),
    .b     (b_q[CHUNK-1:0]),
    .cin   (carry_q),
    .s     (chunk_s),
    .cout  (chunk_cout),
    .c_msb (chunk_cmsb)
  );

  // New chunk enters at the top so the first (least significant) chunk ends at bit 0.
  if (CHUNK == WIDTH) begin : g_sum_full
    assign sum_shifted = chunk_s;
  end else begin : g_sum_shift
    assign sum_shifted = {chunk_s, sum_q[WIDTH-1:CHUNK]};
  end

  assign accept     = in_valid && in_ready;
  assign drain      = out_valid && out_ready;
  assign last_chunk = (idx_q == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)     state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    if (drain)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = !rst;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    if (accept) begin
      a_d     = a;
      b_d     = b;
      carry_d = ci;
      idx_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> CHUNK;
      b_d     = b_q >> CHUNK;
      sum_d   = sum_shifted;
      carry_d = chunk_cout;
      idx_d   = idx_q + 1'b1;
      if (last_chunk) begin
        co_d  = chunk_cout;
        ovf_d = chunk_cout ^ chunk_cmsb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign sum = sum_q;
  assign co  = co_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: three instances (CHUNK 4, 32, 1) share one
// input stream and are compared against a plain-arithmetic reference model.
module tb_chunked_serial_adder;

  localparam int W  = 32;
  localparam int NI = 3;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic         ci;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic         in_ready_w  [NI];
  logic         out_valid_w [NI];
  logic         co_w        [NI];
  logic         ovf_w       [NI];
  logic [W-1:0] sum_w       [NI];

  int lat_exp [NI] = '{8, 1, 32};

  chunked_serial_adder #(.WIDTH(W), .CHUNK(4)) u_dut_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .sum(sum_w[0]), .co(co_w[0]), .ovf(ovf_w[0])
  );

  chunked_serial_adder #(.WIDTH(W), .CHUNK(32)) u_dut_c32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .sum(sum_w[1]), .co(co_w[1]), .ovf(ovf_w[1])
  );

  chunked_serial_adder #(.WIDTH(W), .CHUNK(1)) u_dut_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .sum(sum_w[2]), .co(co_w[2]), .ovf(ovf_w[2])
  );

  // Scoreboard: expected {ovf, co, sum}
  int             checks = 0;
  int             errors = 0;
  logic [W+1:0]   exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact unsigned sum; signed overflow when like-signed operands
  // produce a result of the other sign.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mci);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         v;
    full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mci};
    s    = full[W-1:0];
    v    = (ma[W-1] == mb[W-1]) && (s[W-1] != ma[W-1]);
    return {v, full[W], s};
  endfunction

  // Driver: one full operation with `hold` backpressure cycles in DONE.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oci,
                        input int hold);
    int           lat [NI];
    int           k;
    bit           all_done;
    logic [W+1:0] e;
    for (int i = 0; i < NI; i++) chk($sformatf("pre_in_ready%0d", i), 64'(in_ready_w[i]), 64'd1);
    a = oa; b = ob; ci = oci; in_valid = 1'b1;
    exp_q.push_back(model(oa, ob, oci));
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
    for (int i = 0; i < NI; i++) lat[i] = -1;
    k = 0;
    while (k <= 64) begin
      all_done = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (out_valid_w[i] && lat[i] < 0) lat[i] = k;
        if (lat[i] < 0) all_done = 1'b0;
      end
      if (all_done) break;
      @(negedge clk);
      a = $urandom; b = $urandom;
      k++;
    end
    e = exp_q[0];
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("latency%0d", i), 64'(lat[i]), 64'(lat_exp[i]));
      chk($sformatf("sum%0d", i), 64'(sum_w[i]), 64'(e[W-1:0]));
      chk($sformatf("co%0d", i), 64'(co_w[i]), 64'(e[W]));
      chk($sformatf("ovf%0d", i), 64'(ovf_w[i]), 64'(e[W+1]));
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("hold_valid%0d", i), 64'(out_valid_w[i]), 64'd1);
        chk($sformatf("hold_in_ready%0d", i), 64'(in_ready_w[i]), 64'd0);
        chk($sformatf("hold_sum%0d", i), 64'(sum_w[i]), 64'(e[W-1:0]));
        chk($sformatf("hold_co%0d", i), 64'(co_w[i]), 64'(e[W]));
        chk($sformatf("hold_ovf%0d", i), 64'(ovf_w[i]), 64'(e[W+1]));
      end
    end
    // Drain with in_valid high: must not also accept on the drain edge.
    in_valid = 1'b1; a = $urandom; b = $urandom; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("drain_valid%0d", i), 64'(out_valid_w[i]), 64'd0);
      chk($sformatf("drain_in_ready%0d", i), 64'(in_ready_w[i]), 64'd1);
      chk($sformatf("drain_sum%0d", i), 64'(sum_w[i]), 64'(e[W-1:0]));
    end
    void'(exp_q.pop_front());
  endtask

  task automatic reset_mid_run();
    a = $urandom; b = $urandom; ci = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_valid%0d", i), 64'(out_valid_w[i]), 64'd0);
      chk($sformatf("rst_in_ready%0d", i), 64'(in_ready_w[i]), 64'd0);
      chk($sformatf("rst_sum%0d", i), 64'(sum_w[i]), 64'd0);
      chk($sformatf("rst_co%0d", i), 64'(co_w[i]), 64'd0);
      chk($sformatf("rst_ovf%0d", i), 64'(ovf_w[i]), 64'd0);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) chk($sformatf("rst_rel_in_ready%0d", i), 64'(in_ready_w[i]), 64'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("init_valid%0d", i), 64'(out_valid_w[i]), 64'd0);
      chk($sformatf("init_in_ready%0d", i), 64'(in_ready_w[i]), 64'd0);
      chk($sformatf("init_sum%0d", i), 64'(sum_w[i]), 64'd0);
      chk($sformatf("init_co%0d", i), 64'(co_w[i]), 64'd0);
      chk($sformatf("init_ovf%0d", i), 64'(ovf_w[i]), 64'd0);
    end
    rst = 1'b0;
    #1;

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    run_op(32'h1234_5678, 32'h0FED_CBA8, 1'b1, 2);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);

    reset_mid_run();
    run_op(32'd5, 32'd7, 1'b0, 0);

    for (int n = 0; n < 1000; n++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so a stuck design still reaches the summary.
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
